fp_mult_seq: RTL

FP_MULT_SEQ -- requirements
Module: fp_mult_seq

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_mant_mul_iter.sv | 54 +++++
 rtl/fp_mult_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential FP multiplier.
// Holds FSM states, exponent bias helper and flag bit positions.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mant_mul_iter.sv
// Radix-2 shift-add significand multiplier, one multiplier bit per cycle.
// Ports: start loads operands, busy while iterating, done on last step, product 2N bits.
module fp_mant_mul_iter
  import fp_pkg::*;
#(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_mcd;
  logic [N-1:0]    r_mpl;
  logic [2*N-1:0]  r_acc;
  logic            w_last;

  assign w_last  = (r_cnt == CW'(N - 1));
  assign busy    = r_busy;
  assign done    = r_busy && w_last;
  assign product = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_mcd  <= '0;
      r_mpl  <= '0;
      r_acc  <= '0;
    end else if (start && !r_busy) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_mcd  <= {{N{1'b0}}, mcand};
      r_mpl  <= mplier;
      r_acc  <= '0;
    end else if (r_busy) begin
      r_acc <= r_acc + (r_mpl[0] ? r_mcd : '0);
      r_mcd <= r_mcd << 1;
      r_mpl <= r_mpl >> 1;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential floating-point multiplier, flush-to-zero, fixed latency MAN_W+3.
// Ports: in_valid/in_ready/a/b in, out_valid/out_ready/result/flags out; FP_MULT_ROUND_EN selects RNE.
module fp_mult_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [2:0]               flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 1;
  localparam int PW = 2 * N;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  state_t           r_state, w_next;
  logic [W-1:0]     r_a, r_b, r_result, w_res;
  logic [2:0]       r_flags, w_flg;
  logic             w_start, w_busy, w_done;
  logic [PW-1:0]    w_prod, w_norm;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic             w_sign, w_pmsb, w_inc, w_carry;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic             w_a_zero, w_b_zero, w_ovf, w_unf;
  logic [N-1:0]     w_mant;
  logic [N:0]       w_sum;
  logic [MAN_W-1:0] w_frac;
  logic [EW-1:0]    w_efin;

  assign w_ea   = r_a[W-2:MAN_W];
  assign w_eb   = r_b[W-2:MAN_W];
  assign w_sign = r_a[W-1] ^ r_b[W-1];

  assign w_start = (r_state == MUL) && !w_busy;

  fp_mant_mul_iter #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_start),
    .mcand   ({1'b1, r_a[MAN_W-1:0]}),
    .mplier  ({1'b1, r_b[MAN_W-1:0]}),
    .busy    (w_busy),
    .done    (w_done),
    .product (w_prod)
  );

  assign w_pmsb = w_prod[PW-1];
  assign w_norm = w_pmsb ? w_prod : {w_prod[PW-2:0], 1'b0};
  assign w_mant = w_norm[PW-1:N];

`ifdef FP_MULT_ROUND_EN
  logic w_g, w_r, w_s;
  assign w_g   = w_norm[N-1];
  assign w_r   = w_norm[N-2];
  assign w_s   = |w_norm[N-3:0];
  assign w_inc = w_g & (w_r | w_s | w_norm[N]);
`else
  logic w_unused;
  assign w_unused = ^w_norm[N-1:0];
  assign w_inc    = 1'b0;
`endif

  // rounding carry-out leaves 1.000..0, so the fraction is just zeros
  assign w_sum   = {1'b0, w_mant} + (N+1)'(w_inc);
  assign w_carry = w_sum[N];
  assign w_frac  = w_carry ? w_sum[N-1:1] : w_sum[MAN_W-1:0];

  assign w_efin = {2'b00, w_ea} + {2'b00, w_eb} - BIAS
                + EW'(w_pmsb) + EW'(w_carry);
  assign w_ovf  = !w_efin[EW-1] && (w_efin >= EMAX);
  assign w_unf  = w_efin[EW-1] || (w_efin == '0);

  assign w_a_nan  = (&w_ea) && (|r_a[MAN_W-1:0]);
  assign w_b_nan  = (&w_eb) && (|r_b[MAN_W-1:0]);
  assign w_a_inf  = (&w_ea) && !(|r_a[MAN_W-1:0]);
  assign w_b_inf  = (&w_eb) && !(|r_b[MAN_W-1:0]);
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);

  always_comb begin
    w_res = {w_sign, w_efin[EXP_W-1:0], w_frac};
    w_flg = 3'b000;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero)
        || (w_b_inf && w_a_zero)) begin
      w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_flg[FLAG_INV] = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      w_res = {w_sign, {(W-1){1'b0}}};
    end else if (w_ovf) begin
      w_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flg[FLAG_OVF] = 1'b1;
    end else if (w_unf) begin
      w_res = {w_sign, {(W-1){1'b0}}};
      w_flg[FLAG_UNF] = 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = MUL;
      end
      MUL:  if (w_done) w_next = NORM;
      NORM: w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_next;
      if (in_valid && in_ready) begin
        r_a <= a;
        r_b <= b;
      end
      if (r_state == NORM) begin
        r_result <= w_res;
        r_flags  <= w_flg;
      end
    end
  end

  assign result = r_result;
  assign flags  = r_flags;

endmodule
